// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: debounced pushbutton to single-cycle T flip-flop enable.
// Optional auto-repeat while held is enabled by defining TOGGLE_REPEAT_EN.
`timescale 1ns/1ps
module toggle_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 20000000
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       btn,
   output logic       t,
   output logic       db_level,
   output logic [7:0] press_cnt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CHK,
      HELD,
      REL_CHK
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sync_q;
   logic          btn_s;
   logic          t_q;
   logic          db_q, db_d;
   logic [7:0]    press_q;
   logic          fire;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], btn};
   end

   assign btn_s = sync_q[1];

`ifdef TOGGLE_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_q, rep_d;
   logic          first_q, first_d;
   logic          rep_hit;

   // first_q selects the initial hold delay until the first repeat fires
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         rep_q   <= '0;
         first_q <= 1'b1;
      end else begin
         rep_q   <= rep_d;
         first_q <= first_d;
      end
   end

   assign rep_hit = (rep_q == (first_q ? DELAY_LAST : PERIOD_LAST));
`else
   logic unused_rep;
   assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      fire    = 1'b0;
`ifdef TOGGLE_REPEAT_EN
      rep_d   = rep_q;
      first_d = first_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               db_d    = 1'b1;
               fire    = 1'b1;
`ifdef TOGGLE_REPEAT_EN
               rep_d   = '0;
               first_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_d = REL_CHK;
               cnt_d   = '0;
            end
`ifdef TOGGLE_REPEAT_EN
            // never back-to-back with a previous pulse
            else if (rep_hit) begin
               fire    = !t_q;
               rep_d   = '0;
               first_d = 1'b0;
            end else begin
               rep_d = rep_q + RW'(1);
            end
`endif
         end
         REL_CHK: begin
            if (btn_s) begin
               state_d = HELD;
               cnt_d   = '0;
`ifdef TOGGLE_REPEAT_EN
               rep_d   = '0;
               first_d = 1'b1;
`endif
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               db_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         t_q     <= 1'b0;
         db_q    <= 1'b0;
         press_q <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= fire;
         db_q    <= db_d;
         if (fire) press_q <= press_q + 8'd1;
      end
   end

   assign t         = t_q;
   assign db_level  = db_q;
   assign press_cnt = press_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// tb_toggle_pulse_gen: directed + random bench against a run-length model.
// Build with TOGGLE_REPEAT_EN defined to exercise auto-repeat.
`timescale 1ns/1ps
module tb_toggle_pulse_gen;

   localparam int DB = 8;
   localparam int RD = 20;
   localparam int RP = 5;

   logic       clk   = 1'b0;
   logic       clear = 1'b0;
   logic       btn   = 1'b0;
   logic       t;
   logic       db_level;
   logic [7:0] press_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int n_pulse     = 0;
   bit chk_en      = 1'b0;

   logic [1:0] m_h    = 2'b00;
   logic       m_bs   = 1'b0;
   logic       m_lvl  = 1'b0;
   logic       m_t    = 1'b0;
   logic       m_fire = 1'b0;
   logic [7:0] m_cnt  = 8'd0;
   int         m_run    = 0;
   int         m_streak = 0;

   toggle_pulse_gen #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk      (clk),
      .clear    (clear),
      .btn      (btn),
      .t        (t),
      .db_level (db_level),
      .press_cnt(press_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   // A level is accepted after DB+1 consecutive synchronized samples
   // that disagree with the current level; rising acceptance pulses.
   always @(posedge clk or posedge clear) begin
      if (clear) begin
         m_h      = 2'b00;
         m_lvl    = 1'b0;
         m_t      = 1'b0;
         m_cnt    = 8'd0;
         m_run    = 0;
         m_streak = 0;
      end else begin
         m_bs   = m_h[1];
         m_h    = {m_h[0], btn};
         m_fire = 1'b0;
         if (m_bs != m_lvl) begin
            m_run++;
            m_streak = 0;
            if (m_run == DB + 1) begin
               m_lvl  = m_bs;
               m_run  = 0;
               m_fire = m_bs;
            end
         end else begin
            if (m_lvl && m_run == 0) begin
               m_streak++;
`ifdef TOGGLE_REPEAT_EN
               if (m_streak == RD ||
                   (m_streak > RD && (m_streak - RD) % RP == 0))
                  m_fire = 1'b1;
`endif
            end else begin
               m_streak = 0;
            end
            m_run = 0;
         end
         m_t = m_fire;
         if (m_fire) m_cnt = m_cnt + 8'd1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("t", 32'(t), 32'(m_t));
         check("db_level", 32'(db_level), 32'(m_lvl));
         check("press_cnt", 32'(press_cnt), 32'(m_cnt));
         if (t === 1'b1) n_pulse++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hi, input int lo);
      btn = 1'b1;
      cyc(hi);
      btn = 1'b0;
      cyc(lo);
   endtask

   task automatic clear_pulse();
      @(posedge clk);
      #2 clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      logic [7:0] snap;
      int exp_rep;

      #3 clear = 1'b1;
      cyc(1);
      check("rst_t", 32'(t), 0);
      check("rst_db", 32'(db_level), 0);
      check("rst_cnt", 32'(press_cnt), 0);
      clear  = 1'b0;
      chk_en = 1'b1;

      btn = 1'b1;
      cyc(10);
      check("lat_pre", 32'(t), 0);
      cyc(1);
      check("lat", 32'(t), 1);
      cyc(1);
      check("lat_post", 32'(t), 0);
      check("press_db", 32'(db_level), 1);
      check("press_cnt1", 32'(press_cnt), 1);
      cyc(8);
      btn = 1'b0;
      cyc(10);
      check("rel_pre", 32'(db_level), 1);
      cyc(1);
      check("rel", 32'(db_level), 0);
      check("rel_cnt", 32'(press_cnt), 1);
      cyc(5);

      snap = m_cnt;
      for (int i = 0; i < 5; i++) begin
         btn = (i % 2 == 0);
         cyc(3);
      end
      btn = 1'b0;
      cyc(20);
      check("bounce_cnt", 32'(press_cnt), 32'(snap));
      check("bounce_db", 32'(db_level), 0);

      snap = m_cnt;
      btn = 1'b1;
      cyc(14);
      btn = 1'b0;
      cyc(4);
      btn = 1'b1;
      cyc(12);
      check("glitch_db", 32'(db_level), 1);
      check("glitch_cnt", 32'(press_cnt), 32'(snap + 8'd1));
      btn = 1'b0;
      cyc(15);

      btn = 1'b1;
      cyc(5);
      @(posedge clk);
      #2 clear = 1'b1;
      #1;
      check("mid_t", 32'(t), 0);
      check("mid_cnt", 32'(press_cnt), 0);
      check("mid_db", 32'(db_level), 0);
      @(negedge clk);
      clear = 1'b0;
      cyc(10);
      check("rehold_pre", 32'(t), 0);
      cyc(1);
      check("rehold", 32'(t), 1);
      check("rehold_cnt", 32'(press_cnt), 1);
      #2 clear = 1'b1;
      #1;
      check("tcyc_t", 32'(t), 0);
      check("tcyc_cnt", 32'(press_cnt), 0);
      btn = 1'b0;
      @(negedge clk);
      clear = 1'b0;
      cyc(12);

      for (int i = 0; i < 300; i++) begin
         btn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0)
            cyc(int'($urandom_range(30, 70)));
         else
            cyc(int'($urandom_range(1, 14)));
         if ($urandom_range(0, 39) == 0) clear_pulse();
      end
      btn = 1'b0;
      cyc(15);

      clear_pulse();
      n_pulse = 0;
      for (int i = 0; i < 256; i++) press(12, 12);
      check("wrap_cnt", 32'(press_cnt), 0);
      check("wrap_pulses", 32'(n_pulse), 256);

      clear_pulse();
      n_pulse = 0;
      btn = 1'b1;
      cyc(53);
      btn = 1'b0;
      cyc(20);
`ifdef TOGGLE_REPEAT_EN
      exp_rep = 6;
`else
      exp_rep = 1;
`endif
      check("rep_cnt", 32'(press_cnt), 32'(exp_rep));
      check("rep_pulses", 32'(n_pulse), 32'(exp_rep));

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
